prog_clk_divider: RTL and testbench

- Multi-channel programmable clock-enable/clock divider. It generates up to N divided clocks from one I_CLK.
- Each channel has its own run-time divide ratio, duty cycle (high time), enable and period-end tick.
- Ratio/duty changes and stops take effect only at period boundaries, so outputs are glitch-free.
- A global sync input restarts all running channels in phase.
- It is the parametrised successor of the fixed-ratio toggle divider and sits beside the clock-generation logic, feeding slow clocks and strobes to peripherals.

---
 rtl/clk_div_channel.sv | 131 +++++++++++++
 rtl/prog_clk_divider.sv | 34 +++
 tb/tb_prog_clk_divider.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_channel.sv
// One channel of the programmable clock divider: IDLE/RUN FSM, period
// counter and the divide-ratio / high-time clamp. New ratios are only taken
// at period boundaries (or on a sync restart) so O_CLK never glitches.
module clk_div_channel #(
    parameter int W = 16
) (
    input  logic         I_CLK,
    input  logic         I_RST_N,
    input  logic         I_EN,
    input  logic [W-1:0] I_DIV,
    input  logic [W-1:0] I_HIGH,
    input  logic         I_SYNC,
    output logic         O_CLK,
    output logic         O_TICK,
    output logic         O_BUSY
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] D_MIN = W'(2);
    localparam logic [W-1:0] H_MIN = W'(1);

    // Period is at least 2 cycles so both phases can exist.
    function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
        return (d < D_MIN) ? D_MIN : d;
    endfunction

    // High time is 1..d-1; d must already be clamped.
    function automatic logic [W-1:0] clamp_high(input logic [W-1:0] h,
                                                input logic [W-1:0] d);
        logic [W-1:0] hc;
        hc = (h == '0) ? H_MIN : h;
        if (hc >= d) hc = d - ONE;
        return hc;
    endfunction

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] d_q, d_d;
    logic [W-1:0] h_q, h_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;

    logic [W-1:0] div_c;
    logic [W-1:0] high_c;
    logic [W-1:0] cnt_inc;
    logic         period_end;

    assign div_c      = clamp_div(I_DIV);
    assign high_c     = clamp_high(I_HIGH, div_c);
    assign cnt_inc    = cnt_q + ONE;
    assign period_end = (cnt_q == d_q - ONE);

    // State and output registers; reset parks the channel in IDLE.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= D_MIN;
            h_q     <= H_MIN;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            h_q     <= h_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state: start, count, reload at period end or sync, stop when disabled.
    always_comb begin
        logic load;
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        h_d     = h_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (I_EN) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (I_SYNC || period_end) begin
                    if (I_EN) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        clk_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    clk_d = (cnt_inc < h_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase

        if (load) begin
            d_d    = div_c;
            h_d    = high_c;
            cnt_d  = '0;
            clk_d  = 1'b1;
            tick_d = 1'b1;
        end
    end

    assign O_CLK  = clk_q;
    assign O_TICK = tick_q;
    assign O_BUSY = (state_q == RUN);

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: N independent channels sharing
// one system clock and one global phase-restart pulse.
module prog_clk_divider #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic           I_CLK,
    input  logic           I_RST_N,
    input  logic [N-1:0]   I_EN,
    input  logic [N*W-1:0] I_DIV,
    input  logic [N*W-1:0] I_HIGH,
    input  logic           I_SYNC,
    output logic [N-1:0]   O_CLK,
    output logic [N-1:0]   O_TICK,
    output logic [N-1:0]   O_BUSY
);

    for (genvar k = 0; k < N; k++) begin : g_ch
        clk_div_channel #(
            .W (W)
        ) u_ch (
            .I_CLK   (I_CLK),
            .I_RST_N (I_RST_N),
            .I_EN    (I_EN[k]),
            .I_DIV   (I_DIV[k*W +: W]),
            .I_HIGH  (I_HIGH[k*W +: W]),
            .I_SYNC  (I_SYNC),
            .O_CLK   (O_CLK[k]),
            .O_TICK  (O_TICK[k]),
            .O_BUSY  (O_BUSY[k])
        );
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: table of clamp vectors, hand sequences for the
// multi-cycle corners, and random traffic against a period-origin model.
module tb_prog_clk_divider;

    localparam int N = 4;
    localparam int W = 16;
    localparam int BOUND = 5000;

    logic           I_CLK = 1'b0;
    logic           I_RST_N;
    logic [N-1:0]   I_EN   = '0;
    logic [N*W-1:0] I_DIV  = '0;
    logic [N*W-1:0] I_HIGH = '0;
    logic           I_SYNC = 1'b0;
    logic [N-1:0]   O_CLK;
    logic [N-1:0]   O_TICK;
    logic [N-1:0]   O_BUSY;

    prog_clk_divider #(.N(N), .W(W)) dut (
        .I_CLK   (I_CLK),
        .I_RST_N (I_RST_N),
        .I_EN    (I_EN),
        .I_DIV   (I_DIV),
        .I_HIGH  (I_HIGH),
        .I_SYNC  (I_SYNC),
        .O_CLK   (O_CLK),
        .O_TICK  (O_TICK),
        .O_BUSY  (O_BUSY)
    );

    always #5 I_CLK = ~I_CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;

    always @(posedge I_CLK) cyc++;

    task automatic chk(input string nm, input int k, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s ch%0d: got %0d, expected %0d (cycle %0d)", nm, k, act, exp, cyc);
        end
    endtask

    // Reference model: each running channel remembers the edge at which its
    // current period was loaded; outputs follow from the distance to that edge.
    bit m_run[N];
    int m_t0[N];
    int m_d[N];
    int m_h[N];
    int ecnt = 0;

    function automatic int clampd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int clamph(input int h, input int d);
        int x;
        x = (h < 1) ? 1 : h;
        if (x > d - 1) x = d - 1;
        return x;
    endfunction

    always @(posedge I_CLK or negedge I_RST_N) begin
        bit ld;
        if (!I_RST_N) begin
            ecnt = 0;
            for (int k = 0; k < N; k++) begin
                m_run[k] = 1'b0;
                m_t0[k]  = 0;
                m_d[k]   = 2;
                m_h[k]   = 1;
            end
        end else begin
            ecnt++;
            for (int k = 0; k < N; k++) begin
                ld = 1'b0;
                if (!m_run[k]) begin
                    ld = I_EN[k];
                end else if (I_SYNC || ((ecnt - 1 - m_t0[k]) == m_d[k] - 1)) begin
                    if (I_EN[k]) ld = 1'b1;
                    else         m_run[k] = 1'b0;
                end
                if (ld) begin
                    m_run[k] = 1'b1;
                    m_t0[k]  = ecnt;
                    m_d[k]   = clampd(int'(I_DIV[k*W +: W]));
                    m_h[k]   = clamph(int'(I_HIGH[k*W +: W]), m_d[k]);
                end
            end
        end
    end

    function automatic int exp_clk(input int k);
        return (m_run[k] && (ecnt - m_t0[k]) < m_h[k]) ? 1 : 0;
    endfunction

    function automatic int exp_tick(input int k);
        return (m_run[k] && (ecnt - m_t0[k]) == 0) ? 1 : 0;
    endfunction

    always @(negedge I_CLK) begin
        if (chk_on) begin
            for (int k = 0; k < N; k++) begin
                chk("model_clk",  k, O_CLK[k],  exp_clk(k));
                chk("model_tick", k, O_TICK[k], exp_tick(k));
                chk("model_busy", k, O_BUSY[k], m_run[k] ? 1 : 0);
            end
        end
    end

    task automatic set_ch(input int k, input bit en, input int d, input int h);
        I_EN[k] = en;
        I_DIV[k*W +: W]  = W'(d);
        I_HIGH[k*W +: W] = W'(h);
    endtask

    task automatic wait_tick(input int k, output int t);
        int n;
        n = 0;
        do begin
            @(negedge I_CLK);
            n++;
        end while (!O_TICK[k] && n < BOUND);
        if (!O_TICK[k]) begin
            n_fail++;
            $display("FAIL tick_timeout ch%0d: no tick within %0d cycles", k, BOUND);
        end
        t = cyc;
    endtask

    // Called at a tick negedge; counts cycles and high cycles up to the next tick.
    task automatic measure(input int k, output int per, output int hi);
        per = 0;
        hi  = 0;
        do begin
            per++;
            hi += int'(O_CLK[k]);
            @(negedge I_CLK);
        end while (!O_TICK[k] && per < BOUND);
    endtask

    typedef struct {
        int div;
        int high;
        int per;
        int hi;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int per, hi, ta, tb, tc, ts, t;

        tbl[0] = '{div: 0,  high: 0, per: 2,  hi: 1};
        tbl[1] = '{div: 4,  high: 9, per: 4,  hi: 3};
        tbl[2] = '{div: 1,  high: 1, per: 2,  hi: 1};
        tbl[3] = '{div: 10, high: 5, per: 10, hi: 5};
        tbl[4] = '{div: 7,  high: 7, per: 7,  hi: 6};
        tbl[5] = '{div: 3,  high: 0, per: 3,  hi: 1};
        tbl[6] = '{div: 5,  high: 2, per: 5,  hi: 2};

        // Reset state
        I_RST_N = 1'b1;
        #1 I_RST_N = 1'b0;
        set_ch(0, 1'b1, 10, 5);
        @(posedge I_CLK);
        #1 chk_on = 1'b1;
        repeat (2) @(negedge I_CLK);
        for (int k = 0; k < N; k++) begin
            chk("reset_clk",  k, O_CLK[k],  0);
            chk("reset_tick", k, O_TICK[k], 0);
            chk("reset_busy", k, O_BUSY[k], 0);
        end

        // Start from reset release: rise one cycle after EN is sampled
        #2 I_RST_N = 1'b1;
        @(negedge I_CLK);
        chk("start_clk",  0, O_CLK[0],  1);
        chk("start_tick", 0, O_TICK[0], 1);
        measure(0, per, hi);
        chk("start_period", 0, per, 10);
        chk("start_high",   0, hi,  5);

        // Clamp table on channel 1
        for (int i = 0; i < 7; i++) begin
            set_ch(1, 1'b1, tbl[i].div, tbl[i].high);
            wait_tick(1, t);
            wait_tick(1, t);
            measure(1, per, hi);
            chk("tbl_period", 1, per, tbl[i].per);
            chk("tbl_high",   1, hi,  tbl[i].hi);
        end

        // Mid-period ratio change takes effect only at the next period
        wait_tick(0, ta);
        repeat (3) @(negedge I_CLK);
        set_ch(0, 1'b1, 6, 5);
        wait_tick(0, tb);
        wait_tick(0, tc);
        chk("midchg_old_period", 0, tb - ta, 10);
        chk("midchg_new_period", 0, tc - tb, 6);

        // Stop requested mid-period completes the period
        set_ch(0, 1'b1, 8, 3);
        wait_tick(0, t);
        wait_tick(0, t);
        per = 1;
        hi  = int'(O_CLK[0]);
        @(negedge I_CLK);
        per++;
        hi += int'(O_CLK[0]);
        I_EN[0] = 1'b0;
        for (int n = 0; n < BOUND; n++) begin
            @(negedge I_CLK);
            if (!O_BUSY[0]) break;
            per++;
            hi += int'(O_CLK[0]);
        end
        chk("stop_period", 0, per, 8);
        chk("stop_high",   0, hi,  3);
        repeat (4) begin
            chk("idle_clk",  0, O_CLK[0],  0);
            chk("idle_busy", 0, O_BUSY[0], 0);
            @(negedge I_CLK);
        end

        // Re-enable before period end cancels the stop
        I_EN[0] = 1'b1;
        wait_tick(0, ta);
        @(negedge I_CLK);
        I_EN[0] = 1'b0;
        repeat (4) @(negedge I_CLK);
        I_EN[0] = 1'b1;
        wait_tick(0, tb);
        chk("cancel_period", 0, tb - ta, 8);
        chk("cancel_busy",   0, O_BUSY[0], 1);

        // Global sync restarts channels in phase
        set_ch(0, 1'b1, 6, 3);
        repeat (3) @(negedge I_CLK);
        set_ch(2, 1'b1, 9, 4);
        repeat (13) @(negedge I_CLK);
        I_SYNC = 1'b1;
        @(negedge I_CLK);
        I_SYNC = 1'b0;
        ts = cyc;
        chk("sync_tick", 0, O_TICK[0], 1);
        chk("sync_tick", 2, O_TICK[2], 1);
        chk("sync_clk",  0, O_CLK[0],  1);
        chk("sync_clk",  2, O_CLK[2],  1);
        wait_tick(0, t);
        chk("sync_period", 0, t - ts, 6);
        wait_tick(2, t);
        chk("sync_period", 2, t - ts, 9);

        // Asynchronous reset in the middle of a high phase
        set_ch(0, 1'b1, 10, 5);
        wait_tick(0, t);
        wait_tick(0, t);
        @(negedge I_CLK);
        #2 I_RST_N = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("areset_clk",  k, O_CLK[k],  0);
            chk("areset_tick", k, O_TICK[k], 0);
            chk("areset_busy", k, O_BUSY[k], 0);
        end
        for (int k = 1; k < N; k++) I_EN[k] = 1'b0;
        @(negedge I_CLK);
        #2 I_RST_N = 1'b1;
        ta = cyc;
        wait_tick(0, t);
        chk("restart_latency", 0, t - ta, 1);
        measure(0, per, hi);
        chk("restart_period", 0, per, 10);
        chk("restart_high",   0, hi,  5);

        // Random traffic checked against the model
        for (int c = 0; c < 2000; c++) begin
            @(negedge I_CLK);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(39) == 0) I_EN[k] = ~I_EN[k];
                if ($urandom_range(29) == 0) begin
                    I_DIV[k*W +: W]  = W'($urandom_range(12));
                    I_HIGH[k*W +: W] = W'($urandom_range(14));
                end
            end
            I_SYNC = ($urandom_range(59) == 0);
        end
        @(negedge I_CLK);
        I_SYNC = 1'b0;
        repeat (4) @(negedge I_CLK);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
